pixel_pack_fifo: RTL

- Downstream neighbour of the pixel processing stage; consumes its 8-bit pixel stream over the same VALID_IN/READY_OUT handshake.
- Packs 4 consecutive pixels into one 32-bit word, little-endian: first pixel in [7:0].
- Buffers packed words in a synchronous FIFO for a 32-bit host/bus reader.
- Tracks frame boundaries and zero-pads and flushes any partial word at end of frame or on request.

---
 rtl/pixel_pkg.sv | 27 ++
 rtl/sync_word_fifo.sv | 90 +++++++++
 rtl/pixel_pack_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel packer and its word FIFO:
//   - pack_state_t : packer control state (ACCEPT / FLUSH)
//   - PIX_W, WORD_W, BYTES_PER_WORD : pixel and packed-word geometry
//   - BCNT_W       : width of the byte-lane counter
//   - idx_width()  : safe index width for a count (never returns 0)
// No ports; imported by pixel_pack_fifo and sync_word_fifo.
// -----------------------------------------------------------------------------
package pixel_pkg;

   typedef enum logic {
      ACCEPT = 1'b0,
      FLUSH  = 1'b1
   } pack_state_t;

   localparam int PIX_W          = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

   // A count of 1 still needs a 1-bit index so declarations stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// -----------------------------------------------------------------------------
// sync_word_fifo
// Parameterised single-clock FIFO with a registered read port.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data this edge (ignored while full)
//   push_data  : word to write
//   pop        : read one word this edge (ignored while empty)
//   rd_data    : popped word, registered; holds its value when no pop occurs
//   rd_valid   : high the cycle after an accepted pop
//   level      : registered word count, 0..DEPTH
//   full/empty : registered, always consistent with level
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module sync_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // addresses with differing wrap bits mean full.
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]    level_reg;
   logic             full_reg, empty_reg;
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;
   logic             push_ok, pop_ok;

   assign push_ok = push && !full_reg;
   assign pop_ok  = pop && !empty_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg + PW'(push_ok);
      rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
   end

   // Storage array kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         // Status flags derive from the next pointers so all three agree.
         level_reg    <= wr_ptr_next - rd_ptr_next;
         empty_reg    <= (wr_ptr_next == rd_ptr_next);
         full_reg     <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                         (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
         rd_valid_reg <= pop_ok;
         if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign level    = level_reg;
   assign full     = full_reg;
   assign empty    = empty_reg;

endmodule

// File: rtl/pixel_pack_fifo.sv
// -----------------------------------------------------------------------------
// pixel_pack_fifo
// Packs 8-bit pixels four at a time into little-endian 32-bit words (first
// pixel in [7:0]) and buffers them in sync_word_fifo for a host reader.
// Partial words are zero-padded and written at end of frame or on flush.
//   clk, rst    : clock and synchronous active-high reset
//   pixel_in    : pixel from the processing stage
//   VALID_IN    : pixel_in valid
//   READY_OUT   : pixel accepted this cycle if VALID_IN (registered state only)
//   flush       : single-cycle request to emit the current partial word
//   rd_en       : reader pops one word
//   rd_data     : popped word (registered)
//   rd_valid    : pulses the cycle after an accepted pop
//   empty/full  : FIFO status
//   level       : FIFO word count
//   frame_done  : one-cycle pulse after the final word of a frame is written
// Optional build macro PIXEL_PACK_FRAME_CNT_EN adds:
//   frame_count : 16-bit wrapping count of frame_done pulses
//   drop_err    : sticky flag, set when rd_en is seen while empty
// -----------------------------------------------------------------------------
module pixel_pack_fifo
   import pixel_pkg::*;
#(
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PIX_W-1:0]              pixel_in,
   input  logic                          VALID_IN,
   output logic                          READY_OUT,
   input  logic                          flush,
   input  logic                          rd_en,
   output logic [WORD_W-1:0]             rd_data,
   output logic                          rd_valid,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_done
`ifdef PIXEL_PACK_FRAME_CNT_EN
   ,
   output logic [15:0]                   frame_count,
   output logic                          drop_err
`endif
);

   localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int IDX_W = idx_width(NPIX);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPIX - 1);
   localparam logic [BCNT_W-1:0] LAST_LANE = BCNT_W'(BYTES_PER_WORD - 1);

   pack_state_t        state_reg, state_next;
   logic [WORD_W-1:0]  pack_reg, pack_next;
   logic [BCNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
   logic [IDX_W-1:0]   pix_idx_reg, pix_idx_next;
   logic               eof_pending_reg, eof_pending_next;
   logic               frame_done_reg, frame_done_next;
   logic               ready_en_reg;

   logic               accept;
   logic               last_pix;
   logic               word_done;
   logic [WORD_W-1:0]  ins_word;
   logic               fifo_push;
   logic [WORD_W-1:0]  fifo_push_data;

   // Stall only when the incoming byte would have to push into a full FIFO.
   assign READY_OUT = ready_en_reg && (state_reg == ACCEPT) &&
                      !((byte_cnt_reg == LAST_LANE) && full);

   assign accept    = VALID_IN && READY_OUT;
   assign last_pix  = (pix_idx_reg == LAST_IDX);
   assign word_done = accept && (byte_cnt_reg == LAST_LANE);

   // Pack register with the incoming pixel dropped into lane byte_cnt.
   // Lanes above byte_cnt are still zero, which provides the padding.
   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         assign ins_word[gi*PIX_W +: PIX_W] =
            (byte_cnt_reg == BCNT_W'(gi)) ? pixel_in : pack_reg[gi*PIX_W +: PIX_W];
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      pack_next        = pack_reg;
      byte_cnt_next    = byte_cnt_reg;
      pix_idx_next     = pix_idx_reg;
      eof_pending_next = eof_pending_reg;
      frame_done_next  = 1'b0;
      fifo_push        = 1'b0;
      fifo_push_data   = pack_reg;

      case (state_reg)
         ACCEPT: begin
            if (accept) begin
               pix_idx_next = last_pix ? '0 : pix_idx_reg + IDX_W'(1);
               if (word_done) begin
                  fifo_push       = 1'b1;
                  fifo_push_data  = ins_word;
                  pack_next       = '0;
                  byte_cnt_next   = '0;
                  frame_done_next = last_pix;
               end else begin
                  pack_next     = ins_word;
                  byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
                  if (last_pix) begin
                     state_next       = FLUSH;
                     eof_pending_next = 1'b1;
                  end
               end
            end
            // A manual flush only matters if bytes are pending and the
            // same-cycle pixel did not already complete the word.
            if (flush && (byte_cnt_reg != '0) && !word_done) begin
               state_next = FLUSH;
            end
         end

         FLUSH: begin
            // Further flush requests are absorbed here.
            if (!full) begin
               fifo_push        = 1'b1;
               fifo_push_data   = pack_reg;
               pack_next        = '0;
               byte_cnt_next    = '0;
               state_next       = ACCEPT;
               frame_done_next  = eof_pending_reg;
               eof_pending_next = 1'b0;
            end
         end

         default: begin
            state_next = ACCEPT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ACCEPT;
         pack_reg        <= '0;
         byte_cnt_reg    <= '0;
         pix_idx_reg     <= '0;
         eof_pending_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         ready_en_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pack_reg        <= pack_next;
         byte_cnt_reg    <= byte_cnt_next;
         pix_idx_reg     <= pix_idx_next;
         eof_pending_reg <= eof_pending_next;
         frame_done_reg  <= frame_done_next;
         ready_en_reg    <= 1'b1;
      end
   end

   assign frame_done = frame_done_reg;

   sync_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

`ifdef PIXEL_PACK_FRAME_CNT_EN
   logic [15:0] frame_count_reg;
   logic        drop_err_reg;

   // Counter advances on the same edge that raises frame_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count_reg <= '0;
         drop_err_reg    <= 1'b0;
      end else begin
         if (frame_done_next) begin
            frame_count_reg <= frame_count_reg + 16'd1;
         end
         if (rd_en && empty) begin
            drop_err_reg <= 1'b1;
         end
      end
   end

   assign frame_count = frame_count_reg;
   assign drop_err    = drop_err_reg;
`endif

endmodule
